// File: rtl/ps2_command_encoder.sv
// PS/2 keyboard front end: deframes scan bytes, tracks E0/F0 prefixes and maps key makes to 4-bit commands.
// Optional build macro PS2_TYPEMATIC_EN lets auto-repeat makes of a held key emit again.
module ps2_command_encoder #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2Clk,
  input  logic       ps2Data,
  output logic [3:0] outCode,
  output logic       codeValid,
  output logic       frameErr
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic          clk_meta, clk_sync, clk_prev, data_meta, data_sync;
  logic          fall, bit_in;
  state_t        state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shift, shift_n;
  logic          parity, parity_n;
  logic [TW-1:0] to_cnt, to_cnt_n;
  logic          ext, ext_n, brk, brk_n;
  logic          held_vld, held_vld_n, held_ext, held_ext_n;
  logic [7:0]    held_byte, held_byte_n;
  logic [3:0]    code_n;
  logic          valid_n, err_n;
  logic [4:0]    key;
  logic          held_match, suppress;

  // Returns {hit, code}; extended keys only match with the E0 prefix seen.
  function automatic logic [4:0] key_lookup(input logic e, input logic [7:0] b);
    logic [4:0] r;
    r = 5'h0F;
    if (!e) begin
      case (b)
        8'h45: r = 5'h10;
        8'h16: r = 5'h11;
        8'h1E: r = 5'h12;
        8'h26: r = 5'h13;
        8'h2D: r = 5'h14;
        8'h34: r = 5'h15;
        8'h32: r = 5'h16;
        8'h79: r = 5'h1B;
        8'h4E: r = 5'h1C;
        8'h4D: r = 5'h1D;
        8'h2B: r = 5'h1E;
        default: r = 5'h0F;
      endcase
    end else begin
      case (b)
        8'h75: r = 5'h17;
        8'h72: r = 5'h18;
        8'h6B: r = 5'h19;
        8'h74: r = 5'h1A;
        default: r = 5'h0F;
      endcase
    end
    return r;
  endfunction

  assign key        = key_lookup(ext, shift);
  assign held_match = held_vld && (held_ext == ext) && (held_byte == shift);

`ifdef PS2_TYPEMATIC_EN
  assign suppress = 1'b0;
`else
  assign suppress = held_match;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      clk_prev  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
      fall      <= 1'b0;
      bit_in    <= 1'b1;
    end else begin
      clk_meta  <= ps2Clk;
      clk_sync  <= clk_meta;
      clk_prev  <= clk_sync;
      data_meta <= ps2Data;
      data_sync <= data_meta;
      fall      <= clk_prev & ~clk_sync;
      bit_in    <= data_sync;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      parity    <= 1'b0;
      to_cnt    <= '0;
      ext       <= 1'b0;
      brk       <= 1'b0;
      held_vld  <= 1'b0;
      held_ext  <= 1'b0;
      held_byte <= '0;
      outCode   <= 4'hF;
      codeValid <= 1'b0;
      frameErr  <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shift     <= shift_n;
      parity    <= parity_n;
      to_cnt    <= to_cnt_n;
      ext       <= ext_n;
      brk       <= brk_n;
      held_vld  <= held_vld_n;
      held_ext  <= held_ext_n;
      held_byte <= held_byte_n;
      outCode   <= code_n;
      codeValid <= valid_n;
      frameErr  <= err_n;
    end
  end

  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    shift_n     = shift;
    parity_n    = parity;
    ext_n       = ext;
    brk_n       = brk;
    held_vld_n  = held_vld;
    held_ext_n  = held_ext;
    held_byte_n = held_byte;
    code_n      = 4'hF;
    valid_n     = 1'b0;
    err_n       = 1'b0;

    if (state == S_IDLE || fall) to_cnt_n = '0;
    else                         to_cnt_n = to_cnt + TW'(1);

    // An edge takes priority over a coincident timeout.
    if (fall) begin
      case (state)
        S_IDLE: begin
          if (!bit_in) begin
            state_n   = S_DATA;
            bit_cnt_n = '0;
          end
        end
        S_DATA: begin
          shift_n   = {bit_in, shift[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = S_PARITY;
        end
        S_PARITY: begin
          parity_n = bit_in;
          state_n  = S_STOP;
        end
        S_STOP: begin
          state_n = S_IDLE;
          if (bit_in && ((^shift) ^ parity)) begin
            if (shift == 8'hE0) begin
              ext_n = 1'b1;
            end else if (shift == 8'hF0) begin
              brk_n = 1'b1;
            end else begin
              ext_n = 1'b0;
              brk_n = 1'b0;
              if (brk) begin
                if (held_match) held_vld_n = 1'b0;
              end else if (key[4] && !suppress) begin
                code_n      = key[3:0];
                valid_n     = 1'b1;
                held_vld_n  = 1'b1;
                held_ext_n  = ext;
                held_byte_n = shift;
              end
            end
          end else begin
            err_n = 1'b1;
            ext_n = 1'b0;
            brk_n = 1'b0;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end else if (state != S_IDLE && to_cnt == TO_LAST) begin
      state_n = S_IDLE;
      err_n   = 1'b1;
      ext_n   = 1'b0;
      brk_n   = 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_command_encoder.sv
// Bench for ps2_command_encoder: directed test-plan frames then random frames, checked against a frame-level model.
module tb_ps2_command_encoder;

  localparam int TO   = 200;
  localparam int HALF = 8;
  localparam int ERR  = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       ps2Clk = 1'b1;
  logic       ps2Data = 1'b1;
  logic [3:0] outCode;
  logic       codeValid;
  logic       frameErr;

  int checks = 0;
  int errors = 0;
  int viol   = 0;
  int n5     = 0;
  int ev_q[$];

  int km_ext [15] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
  int km_byte[15] = '{'h45, 'h16, 'h1E, 'h26, 'h2D, 'h34, 'h32,
                      'h75, 'h72, 'h6B, 'h74, 'h79, 'h4E, 'h4D, 'h2B};

  bit m_ext, m_brk, m_hv, m_he;
  int m_hb;

  ps2_command_encoder #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .ps2Clk(ps2Clk), .ps2Data(ps2Data),
    .outCode(outCode), .codeValid(codeValid), .frameErr(frameErr)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (codeValid) ev_q.push_back(int'(outCode));
    if (frameErr) ev_q.push_back(ERR);
    if (codeValid !== (outCode !== 4'hF)) viol++;
    if (codeValid === 1'b1 && outCode === 4'h5) n5++;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  function automatic int model_key(input bit e, input int b);
    for (int i = 0; i < 15; i++)
      if (km_ext[i] == int'(e) && km_byte[i] == b) return i;
    return -1;
  endfunction

  function automatic void model_reset();
    m_ext = 0; m_brk = 0; m_hv = 0; m_he = 0; m_hb = 0;
  endfunction

  // Expected event for one complete frame: -1 none, 0..14 a code, ERR an error pulse.
  function automatic int model_frame(input int b, input bit good);
    int k, r;
    bit same;
    if (!good) begin
      m_ext = 0; m_brk = 0;
      return ERR;
    end
    if (b == 'hE0) begin m_ext = 1; return -1; end
    if (b == 'hF0) begin m_brk = 1; return -1; end
    k = model_key(m_ext, b);
    same = m_hv && (m_he == m_ext) && (m_hb == b);
    r = -1;
    if (m_brk) begin
      if (same) m_hv = 0;
    end else if (k >= 0) begin
`ifdef PS2_TYPEMATIC_EN
      r = k;
`else
      if (!same) r = k;
`endif
      if (r >= 0) begin m_hv = 1; m_he = m_ext; m_hb = b; end
    end
    m_ext = 0; m_brk = 0;
    return r;
  endfunction

  task automatic send_bits(input int b, input bit bad_par, input bit bad_stop, input int nbits);
    logic [7:0]  d;
    logic [10:0] fr;
    d  = b[7:0];
    fr = {~bad_stop, (~^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2Data = fr[i];
      wait_cyc(HALF);
      ps2Clk = 1'b0;
      wait_cyc(HALF);
      ps2Clk = 1'b1;
    end
    ps2Data = 1'b1;
  endtask

  task automatic run_frame(input string tag, input int b, input bit bad_par, input bit bad_stop);
    int exp;
    ev_q.delete();
    send_bits(b, bad_par, bad_stop, 11);
    wait_cyc(12);
    exp = model_frame(b, !bad_par && !bad_stop);
    check({tag, "_nev"}, ev_q.size(), (exp >= 0) ? 1 : 0);
    if (ev_q.size() == 1 && exp >= 0) check({tag, "_ev"}, ev_q[0], exp);
  endtask

  initial begin
    int sel, b, last_key;
    model_reset();
    wait_cyc(4);
    check("rst_outCode", int'(outCode), 15);
    check("rst_codeValid", int'(codeValid), 0);
    check("rst_frameErr", int'(frameErr), 0);
    reset = 1'b0;
    wait_cyc(6);
    check("idle_outCode", int'(outCode), 15);

    // Basic make and the extended make/break sequence
    run_frame("make_2D", 'h2D, 0, 0);
    run_frame("ext_E0", 'hE0, 0, 0);
    run_frame("ext_75", 'h75, 0, 0);
    run_frame("brk_E0", 'hE0, 0, 0);
    run_frame("brk_F0", 'hF0, 0, 0);
    run_frame("brk_75", 'h75, 0, 0);
    run_frame("noext_75", 'h75, 0, 0);

    // Parity and stop-bit errors, then recovery
    run_frame("badpar_16", 'h16, 1, 0);
    run_frame("good_16", 'h16, 0, 0);
    run_frame("badstop_26", 'h26, 0, 1);
    run_frame("good_26", 'h26, 0, 0);

    // Timeout mid-frame also drops a pending E0 prefix
    run_frame("to_E0", 'hE0, 0, 0);
    ev_q.delete();
    send_bits('h2D, 0, 0, 5);
    wait_cyc(TO + 40);
    check("timeout_nev", ev_q.size(), 1);
    if (ev_q.size() == 1) check("timeout_ev", ev_q[0], ERR);
    m_ext = 0; m_brk = 0;
    run_frame("after_to_75", 'h75, 0, 0);
    run_frame("after_to_2B", 'h2B, 0, 0);

    // Held key suppression / typematic
    n5 = 0;
    run_frame("tm_34a", 'h34, 0, 0);
    run_frame("tm_34b", 'h34, 0, 0);
    run_frame("tm_34c", 'h34, 0, 0);
    run_frame("tm_F0", 'hF0, 0, 0);
    run_frame("tm_34brk", 'h34, 0, 0);
    run_frame("tm_34d", 'h34, 0, 0);
`ifdef PS2_TYPEMATIC_EN
    check("typematic_count", n5, 4);
`else
    check("typematic_count", n5, 2);
`endif

    // Reset mid-frame
    ev_q.delete();
    send_bits('h4D, 0, 0, 5);
    wait_cyc(3);
    reset = 1'b1;
    wait_cyc(3);
    check("midrst_outCode", int'(outCode), 15);
    reset = 1'b0;
    model_reset();
    wait_cyc(10);
    check("midrst_nev", ev_q.size(), 0);
    run_frame("after_rst_4D", 'h4D, 0, 0);

    // Random frames
    last_key = 'h45;
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 4) begin
        b = km_byte[$urandom_range(0, 14)];
        last_key = b;
      end else if (sel == 5) b = 'hE0;
      else if (sel == 6) b = 'hF0;
      else if (sel == 7) b = $urandom_range(0, 255);
      else b = last_key;
      run_frame($sformatf("rnd%0d_%02h", i, b), b,
                $urandom_range(0, 9) == 0, $urandom_range(0, 14) == 0);
    end

    check("cv_consistency", viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_command_encoder.md
# ps2_command_encoder

Front end of the VGA controller's user-input path. It receives PS/2 keyboard frames, tracks the `E0` (extended) and `F0` (break) prefixes, and maps the make code of each supported key to the 4-bit command code consumed by the input decoder. Each recognised key press produces a single-cycle command. In every other cycle the block drives the idle code `4'hF`, which the decoder ignores.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 50000: number of `clock` cycles without a PS/2 clock falling edge, while mid-frame, before the frame is aborted.

Ports:
- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `ps2Clk`  in  1  raw PS/2 clock line. Asynchronous to `clock`.
- `ps2Data`  in  1  raw PS/2 data line. Asynchronous to `clock`.
- `outCode`  out  4  command code. `4'hF` when idle.
- `codeValid`  out  1  high for exactly the cycle in which `outCode` is not `4'hF`.
- `frameErr`  out  1  one-cycle pulse on a framing error, parity error or timeout.

## Operation
- **Input synchronisation:** `ps2Clk` and `ps2Data` each pass through a 2-flop synchroniser. A falling edge is detected when the synchronised clock was 1 in the previous cycle and is 0 now. `ps2Data` is sampled only in detect cycles.
- **Frame FSM**, one transition per detected edge:
  - IDLE → DATA if the sampled bit is 0 (start bit). If the sampled bit is 1, stay in IDLE (no error).
  - DATA: shift in 8 bits, LSB first, using a 3-bit counter. After bit 7, go to PARITY.
  - PARITY: store the parity bit, then go to STOP.
  - STOP: the frame is good if stop = 1 and (data XOR-reduced XOR parity) = 1 (odd parity). Any other result is an error. Return to IDLE in both cases.
- **Timeout:**
  - The counter is cleared on every detected edge and in IDLE.
  - It reaching `TIMEOUT_CYCLES-1` while not in IDLE aborts the frame: return to IDLE, pulse `frameErr`, clear the prefix flags.
  - If an edge and a terminal count occur in the same cycle, the edge wins.
- **Prefix handling** on a good byte:
  - `E0` sets `ext`. `F0` sets `brk`. Neither emits a code.
  - Any other byte is decoded together with the current `ext`/`brk`, then both flags are cleared.
- **Error handling:** a bad frame clears `ext`/`brk` and emits nothing.
- **Key map** (make codes only; a break code never emits):
  - `45`→0, `16`→1, `1E`→2, `26`→3
  - `2D`(R)→4, `34`(G)→5, `32`(B)→6
  - `E0 75`(Up)→7, `E0 72`(Down)→8, `E0 6B`(Left)→9, `E0 74`(Right)→A
  - `79`(KP+)→B, `4E`(−)→C, `4D`(P)→D, `2B`(F)→E
  - Any other byte, or a valid byte with a mismatched `ext` flag, produces no output.
- **Held-key register:** holds {`ext`, byte} of the last emitted key plus a valid bit. It is loaded when a code is emitted. It is cleared when a break code for the same {`ext`, byte} arrives.

## Timing
- **Reset values:**
  - Outputs: `outCode`=`4'hF`, `codeValid`=0, `frameErr`=0.
  - Internal: FSM=IDLE, bit counter=0, timeout counter=0, `ext`=`brk`=0, held-key register invalid, synchroniser flops=1.
- **Reset mid-frame:** aborts the frame with no output and no `frameErr`.
- **Output latency:** the stop-bit edge is detected in cycle N. `outCode`/`codeValid` (or `frameErr`) are registered and asserted in cycle N+1 for exactly one cycle. They return to `4'hF`/0 in N+2.
- **Pin-to-detect latency:** 3 `clock` cycles (two synchroniser stages plus the edge register).
- **Output spacing:** at most one output event per frame. Consecutive codes are therefore at least 11 PS/2 clock periods apart.
- **Output format:** all outputs are registered; there are no combinational paths from inputs.

## Configuration
- **`PS2_TYPEMATIC_EN` defined:** every make code of a mapped key emits a command, including auto-repeat makes while the key is held. The held-key register still tracks state but never suppresses output.
- **`PS2_TYPEMATIC_EN` undefined (default):** a make whose {`ext`, byte} equals the valid held-key entry is suppressed. Only the first make after the matching break emits. A make of a different key emits and replaces the held entry.

## Test plan
- **Basic make:** reset, then frame `2D` with correct parity → `outCode`=4, `codeValid`=1 for one cycle, then `4'hF`/0.
- **Extended make/break:** `E0 75` → single `outCode`=7. `E0 F0 75` → no output. `75` alone → no output.
- **Bad parity:** frame `16` with even parity → `frameErr` pulse, no code. The next good `16` → `outCode`=1.
- **Timeout:** stop `ps2Clk` after 4 data bits for `TIMEOUT_CYCLES` cycles → `frameErr` pulse and FSM back in IDLE. A following good `2B` → `outCode`=E.
- **Typematic:** `34` ×3, then `F0 34`, then `34`:
  - without `PS2_TYPEMATIC_EN` → exactly two `outCode`=5 pulses;
  - with `PS2_TYPEMATIC_EN` → four pulses.
- **Reset mid-frame:** assert `reset` after 5 bits of `4D`, release, send `4D` → exactly one `outCode`=D, no `frameErr`.
